// File: rtl/main.sv
`default_nettype none
// main: LED blinker; LED1 toggles every N clock cycles, LED2 is its complement.
// Revision 1.0
module main #(
  parameter int N = 6000000
) (
  input  logic CLK,
  input  logic RST,
  output logic LED1,
  output logic LED2
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  // Power-up values match the reset values so RST may be tied low.
  logic [W-1:0] cnt = '0;
  logic         led = 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      led <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      led <= ~led;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign LED1 = led;
  assign LED2 = ~led;

endmodule
`default_nettype wire

// File: tb/tb_main.sv
`default_nettype none
// tb_main: checks four blinker instances (N = 3, 1, 4, 7) against an edge-count model.
// Revision 1.0
module tb_main;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst = 4'b0000;
  logic [3:0] l1;
  logic [3:0] l2;

  localparam int NS [4] = '{3, 1, 4, 7};

  main #(.N(3)) dut3 (.CLK(clk), .RST(rst[0]), .LED1(l1[0]), .LED2(l2[0]));
  main #(.N(1)) dut1 (.CLK(clk), .RST(rst[1]), .LED1(l1[1]), .LED2(l2[1]));
  main #(.N(4)) dut4 (.CLK(clk), .RST(rst[2]), .LED1(l1[2]), .LED2(l2[2]));
  main #(.N(7)) dut7 (.CLK(clk), .RST(rst[3]), .LED1(l1[3]), .LED2(l2[3]));

  int checks = 0;
  int fails  = 0;

  // Model: k = rising edges seen with RST low since the last reset edge;
  // LED1 is high during odd half-periods, i.e. when floor(k/N) is odd.
  int kcnt [4] = '{0, 0, 0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      kcnt[i] <= rst[i] ? 0 : kcnt[i] + 1;
  end

  function automatic logic exp_led(input int k, input int n);
    return ((k / n) % 2) == 1;
  endfunction

  task automatic test_powerup_blink();
    logic [11:0] pat3;
    pat3 = 12'b111000111000;  // bit j = LED1 after j edges for N=3
    #1;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (l1[i] !== exp_led(kcnt[i], NS[i])) begin
          fails++;
          $display("FAIL powerup N=%0d edge%0d: LED1=%b expected %b", NS[i], j, l1[i], exp_led(kcnt[i], NS[i]));
        end
        checks++;
        if (l2[i] !== ~l1[i] || $isunknown(l1[i])) begin
          fails++;
          $display("FAIL powerup_compl N=%0d edge%0d: LED2=%b LED1=%b required complement", NS[i], j, l2[i], l1[i]);
        end
      end
      if (j < 12) begin
        checks++;
        if (l1[0] !== pat3[j]) begin
          fails++;
          $display("FAIL pattern_n3 edge%0d: LED1=%b expected %b", j, l1[0], pat3[j]);
        end
      end
      checks++;
      if (l1[1] !== j[0]) begin
        fails++;
        $display("FAIL alternate_n1 edge%0d: LED1=%b expected %b", j, l1[1], j[0]);
      end
    end
  endtask

  task automatic test_reset_mid_period();
    int t;
    t = 0;
    while ((kcnt[0] % 6) != 4 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if ((kcnt[0] % 6) != 4 || l1[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_setup: LED1=%b k=%0d expected LED1=1 at cnt=1", l1[0], kcnt[0]);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (l1[0] !== 1'b0 || l2[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: LED1=%b LED2=%b expected 0 1", l1[0], l2[0]);
    end
    rst[0] = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      checks++;
      if (l1[0] !== (e >= 3) || l2[0] !== (e < 3)) begin
        fails++;
        $display("FAIL reset_resume edge%0d: LED1=%b LED2=%b expected %b %b", e, l1[0], l2[0], (e >= 3), (e < 3));
      end
    end
  endtask

  task automatic test_reset_hold();
    rst = 4'b1111;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (l1[i] !== 1'b0 || l2[i] !== 1'b1) begin
          fails++;
          $display("FAIL reset_hold N=%0d edge%0d: LED1=%b LED2=%b expected 0 1", NS[i], e, l1[i], l2[i]);
        end
      end
    end
    rst = 4'b0000;
  endtask

  task automatic test_reset_at_last();
    int t;
    t = 0;
    while ((kcnt[3] % 7) != 6 && t < 20) begin
      @(negedge clk);
      t++;
    end
    rst[3] = 1'b1;
    @(negedge clk);
    rst[3] = 1'b0;
    checks++;
    if (l1[3] !== 1'b0 || l2[3] !== 1'b1) begin
      fails++;
      $display("FAIL reset_at_last: LED1=%b LED2=%b expected 0 1", l1[3], l2[3]);
    end
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      checks++;
      if (l1[3] !== (e >= 7 && e < 14)) begin
        fails++;
        $display("FAIL reset_at_last_resume edge%0d: LED1=%b expected %b", e, l1[3], (e >= 7 && e < 14));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        rst[i] = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (l1[i] !== exp_led(kcnt[i], NS[i]) || l2[i] !== ~exp_led(kcnt[i], NS[i])) begin
          fails++;
          $display("FAIL random N=%0d cycle%0d: LED1=%b LED2=%b expected LED1=%b", NS[i], c, l1[i], l2[i], exp_led(kcnt[i], NS[i]));
        end
      end
    end
    rst = 4'b0000;
  endtask

  initial begin
    test_powerup_blink();
    test_reset_mid_period();
    test_reset_hold();
    test_reset_at_last();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 Parameter: N, default 6000000, clock cycles per LED half-period (0.5 s at 12 MHz, giving a 1 Hz blink); legal range N >= 1.
REQ-002 Port: CLK  input  1  system clock; all state updates on the rising edge only.
REQ-003 Port: RST  input  1  reset, synchronous and active-high.
REQ-004 Port: LED1  output  1  blink output; toggles once every N clock cycles.
REQ-005 Port: LED2  output  1  complement of LED1 at all times.
REQ-006 The block SHALL use one clock domain (CLK) only, with no gated or derived clocks.

Function
REQ-007 Internal state: cycle counter cnt, width max(1, ceil(log2(N))) bits, unsigned, range 0..N-1; one register led (drives LED1).
REQ-008 On each rising CLK edge with RST low: if cnt == N-1, then cnt <= 0 and led <= ~led; otherwise cnt <= cnt + 1 and led holds.
REQ-009 cnt SHALL never take a value >= N, and SHALL never wrap through 2^width.
REQ-010 LED1 SHALL be driven directly from the led register (registered output, no combinational path from cnt).
REQ-011 LED2 SHALL equal ~LED1 combinationally at all times; LED1 and LED2 are never equal and never X/Z after power-up.
REQ-012 Timing from a clean start (cnt=0, led=0):
- LED1 = 0 before rising edges 1..N.
- The N-th rising edge sets LED1 to 1.
- The 2N-th rising edge sets LED1 to 0, and so on; period = 2N cycles, 50% duty.
REQ-013 N == 1: LED1 SHALL toggle on every rising edge; cnt stays 0.
REQ-014 Toggle latency: LED1 changes in the same edge that cnt returns from N-1 to 0, with no extra pipeline cycle.

Reset
REQ-015 RST high at a rising edge SHALL force cnt <= 0 and led <= 0 (LED1=0, LED2=1), overriding counting and toggling, including at cnt == N-1.
REQ-016 Counting SHALL resume on the first rising edge with RST low; LED1 next rises at the N-th such edge.
REQ-017 Power-up/initial register values SHALL equal the reset values (cnt=0, led=0), so the block runs correctly with RST tied low.
REQ-018 Reset asserted mid-period SHALL discard the partial count; there is no asynchronous path from RST to the outputs.

Verification
REQ-019 N=3, RST tied low, sample just before each edge for 12 edges: LED1 = 0,0,0,1,1,1,0,0,0,1,1,1, and LED2 is its complement every cycle.
REQ-020 N=3: assert RST at the edge where cnt=1 and led=1 -> after that edge LED1=0, LED2=1; release RST -> LED1 rises on the 3rd following edge.
REQ-021 N=3: hold RST high for 5 edges -> LED1 stays 0 and LED2 stays 1 throughout; no toggle occurs.
REQ-022 N=1, RST low -> LED1 alternates 0,1,0,1 on successive edges.
REQ-023 N=4 (power of two, cnt width 2) -> LED1 toggles exactly every 4 edges over 16 edges, with no early toggle from counter wrap.
REQ-024 All scenarios: LED1 !== LED2 checked every cycle; any mismatch is a failure.
